// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: machine word, RAM handshake state, and the
// memory responder's internal FSM states.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        DREQ = 3'd1,
        IREQ = 3'd2,
        RESP = 3'd3,
        ERR  = 3'd4
    } resp_state_t;

endpackage

// File: rtl/dp_mem_responder.sv
// Serialises datapath fetch and data requests onto one single-port RAM,
// returning one-cycle ihit/dhit pulses; data beats fetch, no pre-emption.
module dp_mem_responder
    import cpu_types_pkg::*;
#(
    parameter int TIMEOUT = 256
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        halt,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    input  logic        dmemREN,
    input  logic        dmemWEN,
    input  logic [31:0] dmemaddr,
    input  logic [31:0] dmemstore,
    output logic        ihit,
    output logic        dhit,
    output logic [31:0] imemload,
    output logic [31:0] dmemload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    output logic        err
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    resp_state_t   state;
    ramstate_t     ram_st;
    word_t         lat_addr;
    word_t         lat_store;
    logic          lat_write;
    logic [CW-1:0] cnt;
    logic          req_live;

    assign ram_st = ramstate_t'(ramstate);

    // Whether the request being serviced is still asserted; a dropped
    // request finishes its RAM access silently without a hit pulse.
    always_comb begin
        req_live = 1'b0;
        case (state)
            DREQ:    req_live = lat_write ? dmemWEN : dmemREN;
            IREQ:    req_live = imemREN;
            default: req_live = 1'b0;
        endcase
    end

    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        case (state)
            DREQ: begin
                ramaddr = lat_addr;
                if (lat_write) begin
                    ramWEN   = 1'b1;
                    ramstore = lat_store;
                end else begin
                    ramREN = 1'b1;
                end
            end
            IREQ: begin
                ramaddr = lat_addr;
                ramREN  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= IDLE;
            lat_addr  <= '0;
            lat_store <= '0;
            lat_write <= 1'b0;
            cnt       <= '0;
            ihit      <= 1'b0;
            dhit      <= 1'b0;
            imemload  <= '0;
            dmemload  <= '0;
            err       <= 1'b0;
        end else begin
            ihit <= 1'b0;
            dhit <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (dmemWEN || dmemREN) begin
                        state     <= DREQ;
                        lat_addr  <= dmemaddr;
                        lat_store <= dmemstore;
                        lat_write <= dmemWEN;
                    end else if (imemREN && !halt) begin
                        state     <= IREQ;
                        lat_addr  <= imemaddr;
                        lat_write <= 1'b0;
                    end
                end
                DREQ, IREQ: begin
                    if (ram_st == ACCESS) begin
                        state <= RESP;
                        if (req_live) begin
                            if (state == DREQ) begin
                                dhit <= 1'b1;
                                if (!lat_write) dmemload <= ramload;
                            end else begin
                                ihit     <= 1'b1;
                                imemload <= ramload;
                            end
                        end
                    end else if (ram_st == ERROR || cnt == CNT_LAST) begin
                        state <= ERR;
                        err   <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                // The requester still holds the completed request here, so
                // nothing is accepted until IDLE.
                RESP: begin
                    cnt   <= '0;
                    state <= IDLE;
                end
                ERR: begin
                    err <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dp_mem_responder.sv
// Directed bench for dp_mem_responder: the RAM handshake is driven by hand
// cycle by cycle and every expected value is written out explicitly.
module tb_dp_mem_responder;
    import cpu_types_pkg::*;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        halt;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        dmemREN;
    logic        dmemWEN;
    logic [31:0] dmemaddr;
    logic [31:0] dmemstore;
    logic        ihit;
    logic        dhit;
    logic [31:0] imemload;
    logic [31:0] dmemload;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;
    logic        err;

    int checks   = 0;
    int failures = 0;

    dp_mem_responder #(.TIMEOUT(8)) dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .halt      (halt),
        .imemREN   (imemREN),
        .imemaddr  (imemaddr),
        .dmemREN   (dmemREN),
        .dmemWEN   (dmemWEN),
        .dmemaddr  (dmemaddr),
        .dmemstore (dmemstore),
        .ihit      (ihit),
        .dhit      (dhit),
        .imemload  (imemload),
        .dmemload  (dmemload),
        .ramREN    (ramREN),
        .ramWEN    (ramWEN),
        .ramaddr   (ramaddr),
        .ramstore  (ramstore),
        .ramload   (ramload),
        .ramstate  (ramstate),
        .err       (err)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic apply_stimulus(input logic i_ren, input logic [31:0] i_addr,
                                  input logic d_ren, input logic d_wen,
                                  input logic [31:0] d_addr, input logic [31:0] d_store);
        imemREN   = i_ren;
        imemaddr  = i_addr;
        dmemREN   = d_ren;
        dmemWEN   = d_wen;
        dmemaddr  = d_addr;
        dmemstore = d_store;
    endtask

    initial begin
        nRST     = 1'b0;
        halt     = 1'b0;
        ramload  = '0;
        ramstate = FREE;
        apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        tick();

        check_output("reset_ihit", {31'b0, ihit}, 32'd0);
        check_output("reset_dhit", {31'b0, dhit}, 32'd0);
        check_output("reset_imemload", imemload, 32'h0);
        check_output("reset_dmemload", dmemload, 32'h0);
        check_output("reset_ramstrobes", {30'b0, ramREN, ramWEN}, 32'd0);
        check_output("reset_ramaddr", ramaddr, 32'h0);
        check_output("reset_err", {31'b0, err}, 32'd0);
        nRST = 1'b1;
        tick();

        // Fetch with three BUSY cycles then ACCESS
        ramstate = BUSY;
        apply_stimulus(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        for (int i = 0; i < 4; i++) begin
            check_output("t1_ramREN", {31'b0, ramREN}, 32'd1);
            check_output("t1_ramaddr", ramaddr, 32'h40);
            check_output("t1_ihit_early", {31'b0, ihit}, 32'd0);
            if (i == 3) begin
                ramstate = ACCESS;
                ramload  = 32'h2002000A;
            end
            tick();
        end
        check_output("t1_ihit", {31'b0, ihit}, 32'd1);
        check_output("t1_imemload", imemload, 32'h2002000A);
        check_output("t1_ramREN_resp", {31'b0, ramREN}, 32'd0);
        imemREN  = 1'b0;
        ramstate = FREE;
        tick();
        check_output("t1_ihit_pulse", {31'b0, ihit}, 32'd0);
        check_output("t1_idle_ramREN", {31'b0, ramREN}, 32'd0);

        // Data and fetch raised together: data first
        ramstate = BUSY;
        apply_stimulus(1'b1, 32'h44, 1'b1, 1'b0, 32'h100, 32'h0);
        tick();
        check_output("t2_first_addr", ramaddr, 32'h100);
        check_output("t2_strobes", {30'b0, ramREN, ramWEN}, 32'd2);
        ramstate = ACCESS;
        ramload  = 32'h11112222;
        tick();
        check_output("t2_hits_d", {30'b0, ihit, dhit}, 32'd1);
        check_output("t2_dmemload", dmemload, 32'h11112222);
        check_output("t2_ramREN_resp", {31'b0, ramREN}, 32'd0);
        dmemREN  = 1'b0;
        ramstate = BUSY;
        tick();
        check_output("t2_bubble", {29'b0, ihit, dhit, ramREN}, 32'd0);
        tick();
        check_output("t2_fetch_addr", ramaddr, 32'h44);
        check_output("t2_fetch_ren", {31'b0, ramREN}, 32'd1);
        ramstate = ACCESS;
        ramload  = 32'h33334444;
        tick();
        check_output("t2_hits_i", {30'b0, ihit, dhit}, 32'd2);
        check_output("t2_imemload", imemload, 32'h33334444);
        imemREN  = 1'b0;
        ramstate = FREE;
        tick();

        // Write: store data latched at acceptance
        ramstate = BUSY;
        apply_stimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'h80, 32'hDEADBEEF);
        tick();
        check_output("t3_strobes", {30'b0, ramREN, ramWEN}, 32'd1);
        check_output("t3_ramstore", ramstore, 32'hDEADBEEF);
        dmemstore = 32'h12345678;
        tick();
        check_output("t3_ramstore_held", ramstore, 32'hDEADBEEF);
        check_output("t3_ramaddr", ramaddr, 32'h80);
        ramstate = ACCESS;
        ramload  = 32'hCAFEF00D;
        tick();
        check_output("t3_dhit", {31'b0, dhit}, 32'd1);
        check_output("t3_dmemload_kept", dmemload, 32'h11112222);
        check_output("t3_ramWEN_resp", {31'b0, ramWEN}, 32'd0);
        dmemWEN  = 1'b0;
        ramstate = FREE;
        tick();

        // halt blocks fetches but not data
        halt     = 1'b1;
        ramstate = BUSY;
        apply_stimulus(1'b1, 32'h50, 1'b0, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_output("t4_halt_noREN", {31'b0, ramREN}, 32'd0);
        end
        dmemREN  = 1'b1;
        dmemaddr = 32'h200;
        tick();
        check_output("t4_data_addr", ramaddr, 32'h200);
        check_output("t4_data_ren", {31'b0, ramREN}, 32'd1);
        ramstate = ACCESS;
        ramload  = 32'hA5A5A5A5;
        tick();
        check_output("t4_hits", {30'b0, ihit, dhit}, 32'd1);
        check_output("t4_dmemload", dmemload, 32'hA5A5A5A5);
        dmemREN  = 1'b0;
        ramstate = BUSY;
        tick();
        tick();
        check_output("t4_halt_still_blocks", {31'b0, ramREN}, 32'd0);
        halt    = 1'b0;
        imemREN = 1'b0;
        tick();

        // Fetch dropped during ACCESS: no ihit, imemload unchanged
        apply_stimulus(1'b1, 32'h60, 1'b0, 1'b0, 32'h0, 32'h0);
        ramstate = BUSY;
        tick();
        check_output("sup_ren", {31'b0, ramREN}, 32'd1);
        imemREN  = 1'b0;
        ramstate = ACCESS;
        ramload  = 32'h77777777;
        tick();
        check_output("sup_no_ihit", {31'b0, ihit}, 32'd0);
        check_output("sup_imemload", imemload, 32'h33334444);
        ramstate = FREE;
        tick();

        // Timeout: RAM held BUSY for TIMEOUT=8 access cycles
        ramstate = BUSY;
        apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h300, 32'h0);
        tick();
        for (int i = 0; i < 8; i++) begin
            check_output("t5_pre_err", {30'b0, err, ramREN}, 32'd1);
            tick();
        end
        check_output("t5_err", {31'b0, err}, 32'd1);
        check_output("t5_ram_idle", {30'b0, ramREN, ramWEN}, 32'd0);
        check_output("t5_ramaddr", ramaddr, 32'h0);
        ramstate = ACCESS;
        tick();
        tick();
        check_output("t5_sticky", {29'b0, err, dhit, ramREN}, 32'd4);
        dmemREN  = 1'b0;
        ramstate = FREE;
        nRST     = 1'b0;
        #2;
        check_output("t5_err_cleared", {31'b0, err}, 32'd0);
        nRST = 1'b1;
        tick();

        // RAM reports ERROR
        ramstate = BUSY;
        apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h310, 32'h0);
        tick();
        ramstate = ERROR;
        tick();
        check_output("t5_ramerror_err", {30'b0, err, ramREN}, 32'd2);
        dmemREN  = 1'b0;
        ramstate = FREE;
        nRST     = 1'b0;
        #2;
        nRST = 1'b1;
        tick();

        // Reset mid-access
        ramstate = BUSY;
        apply_stimulus(1'b1, 32'h80, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        check_output("t6_ren_before", {31'b0, ramREN}, 32'd1);
        nRST = 1'b0;
        #1;
        check_output("t6_ren_async", {31'b0, ramREN}, 32'd0);
        check_output("t6_ramaddr_async", ramaddr, 32'h0);
        ramstate = ACCESS;
        ramload  = 32'h99999999;
        tick();
        check_output("t6_no_hit", {30'b0, ihit, dhit}, 32'd0);
        imemREN  = 1'b0;
        ramstate = FREE;
        nRST     = 1'b1;
        tick();
        check_output("t6_after_hits", {29'b0, ihit, dhit, ramREN}, 32'd0);
        check_output("t6_imemload", imemload, 32'h0);
        check_output("t6_dmemload", dmemload, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
